// File: rtl/alu_logic_issue.sv
// Command queue feeding an external logic unit (AND/OR).
// One registered result slot with valid/ready handshake on both sides.
module alu_logic_issue #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_a,
  input  logic [3:0]             in_b,
  input  logic [1:0]             in_opcode,
  output logic [3:0]             lu_a,
  output logic [3:0]             lu_b,
  output logic [1:0]             lu_opcode,
  input  logic [3:0]             lu_y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_y,
  output logic                   out_zero,
  output logic                   out_err,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          push;
  logic          issue;

  assign empty    = (count == '0);
  assign in_ready = (count < FULL);
  assign push     = in_valid && in_ready;
  assign issue    = !empty && (!out_valid || out_ready);
  assign head     = mem[rd_ptr];

  // Head is masked while empty so stale storage never leaks out.
  always_comb begin
    lu_a      = '0;
    lu_b      = '0;
    lu_opcode = '0;
    if (!empty) begin
      lu_a      = head.a;
      lu_b      = head.b;
      lu_opcode = head.op;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: in_a, b: in_b, op: in_opcode};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (issue) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_zero  <= 1'b0;
      out_err   <= 1'b0;
    end else if (issue) begin
      out_valid <= 1'b1;
      if (head.op[1]) begin
        out_y    <= lu_y;
        out_zero <= (lu_y == 4'b0000);
        out_err  <= 1'b0;
      end else begin
        out_y    <= '0;
        out_zero <= 1'b1;
        out_err  <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
